// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
// Revision : 1.0
// ============================================================================
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [7:0] LOAD_CMD   = 8'h4C;
    localparam logic [1:0] WSIZE_WORD = 2'b10;
    localparam int         NB_BYTE    = 8;

    // True when a word count does not fit in a memory of 2^(aw-2) words.
    function automatic logic len_oversize(input logic [7:0] n, input int aw);
        return int'(n) > (1 << (aw - 2));
    endfunction

endpackage : loader_pkg
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Purpose  : Little-endian byte-to-word packer with a lane counter and a
//            combinational word-ready strobe on the fourth byte.
// Revision : 1.0
// ============================================================================
module word_assembler
    import loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [NB_BYTE-1:0]   i_byte,
    output logic [4*NB_BYTE-1:0] o_word,
    output logic                 o_word_ready
);

    logic [1:0]           r_byte_idx;
    logic [3*NB_BYTE-1:0] r_low;

    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_byte_idx <= 2'd0;
            r_low      <= '0;
        end else if (i_valid) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
                2'd0:    r_low[NB_BYTE-1:0]           <= i_byte;
                2'd1:    r_low[2*NB_BYTE-1:NB_BYTE]   <= i_byte;
                2'd2:    r_low[3*NB_BYTE-1:2*NB_BYTE] <= i_byte;
                default: r_low                        <= r_low;
            endcase
        end
    end

    // The top lane is never stored: the word is presented while its last byte arrives.
    assign o_word_ready = i_valid && (r_byte_idx == 2'd3);
    assign o_word       = {i_byte, r_low};

endmodule : word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Frames a UART byte stream into instruction-memory word writes and
//            holds the core in reset while a program image is being loaded.
// Revision : 1.0
// ============================================================================
module imem_loader
    import loader_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int NB_INSTRUCTION  = 32,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    output logic [NB_INSTRUCTION-1:0]  o_imem_data,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
    output logic                       o_imem_wen,
    output logic [1:0]                 o_mem_wsize,
    output logic                       o_cpu_en,
    output logic                       o_cpu_rst,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int                TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   c_to_last = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                       r_state;
    state_t                       w_state_next;
    logic [7:0]                   r_words_left;
    logic [7:0]                   w_words_next;
    logic [IMEM_ADDR_WIDTH-1:0]   r_addr;
    logic [IMEM_ADDR_WIDTH-1:0]   w_addr_next;
    logic [TO_W-1:0]              r_to_cnt;
    logic [TO_W-1:0]              w_to_next;
    logic [NB_INSTRUCTION-1:0]    r_imem_data;
    logic [NB_INSTRUCTION-1:0]    w_data_next;
    logic [IMEM_ADDR_WIDTH-1:0]   r_imem_waddr;
    logic [IMEM_ADDR_WIDTH-1:0]   w_waddr_next;
    logic                         r_wen;
    logic                         w_wen_next;
    logic                         r_done;
    logic                         w_done_next;
    logic                         r_err;
    logic                         w_err_next;
    logic                         r_cpu_en;
    logic                         w_cpu_en_next;
    logic                         r_cpu_rst;
    logic                         w_cpu_rst_next;

    logic                         w_asm_valid;
    logic                         w_asm_clear;
    logic [NB_INSTRUCTION-1:0]    w_word;
    logic                         w_word_ready;
    logic                         w_timeout;

    assign w_asm_valid = i_rx_valid && (r_state == ST_LOAD);
    assign w_asm_clear = i_rx_valid && (r_state == ST_LEN);

    word_assembler u_word_assembler (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_clear      (w_asm_clear),
        .i_valid      (w_asm_valid),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    // The counter already reads 1 in the cycle after a strobe, so matching
    // TIMEOUT_CYCLES-1 puts the registered error exactly TIMEOUT_CYCLES later.
    assign w_timeout = (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_words_left <= '0;
            r_addr       <= '0;
            r_to_cnt     <= '0;
            r_imem_data  <= '0;
            r_imem_waddr <= '0;
            r_wen        <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_en     <= 1'b0;
            r_cpu_rst    <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_words_left <= w_words_next;
            r_addr       <= w_addr_next;
            r_to_cnt     <= w_to_next;
            r_imem_data  <= w_data_next;
            r_imem_waddr <= w_waddr_next;
            r_wen        <= w_wen_next;
            r_done       <= w_done_next;
            r_err        <= w_err_next;
            r_cpu_en     <= w_cpu_en_next;
            r_cpu_rst    <= w_cpu_rst_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_words_next   = r_words_left;
        w_addr_next    = r_addr;
        w_to_next      = r_to_cnt;
        w_data_next    = r_imem_data;
        w_waddr_next   = r_imem_waddr;
        w_wen_next     = 1'b0;
        w_done_next    = 1'b0;
        w_err_next     = 1'b0;
        w_cpu_en_next  = r_cpu_en;
        w_cpu_rst_next = r_cpu_rst;

        // Core release lags the done pulse by one cycle; a new start byte overrides it.
        if (r_done) begin
            w_cpu_en_next  = 1'b1;
            w_cpu_rst_next = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                w_to_next = '0;
                if (i_rx_valid && (i_rx_data == LOAD_CMD)) begin
                    w_state_next   = ST_LEN;
                    w_to_next      = TO_W'(1);
                    w_cpu_en_next  = 1'b0;
                    w_cpu_rst_next = 1'b1;
                end
            end
            ST_LEN: begin
                if (i_rx_valid) begin
                    w_to_next = TO_W'(1);
                    if (i_rx_data == 8'd0) begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (len_oversize(i_rx_data, IMEM_ADDR_WIDTH)) begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_words_next = i_rx_data;
                        w_addr_next  = '0;
                        w_state_next = ST_LOAD;
                    end
                end else if (w_timeout) begin
                    w_err_next     = 1'b1;
                    w_state_next   = ST_IDLE;
                    w_cpu_en_next  = 1'b0;
                    w_cpu_rst_next = 1'b1;
                end else begin
                    w_to_next = r_to_cnt + TO_W'(1);
                end
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    w_to_next = TO_W'(1);
                    if (w_word_ready) begin
                        w_data_next  = w_word;
                        w_waddr_next = r_addr;
                        w_wen_next   = 1'b1;
                        w_addr_next  = r_addr + IMEM_ADDR_WIDTH'(4);
                        w_words_next = r_words_left - 8'd1;
                        if (r_words_left == 8'd1) begin
                            w_done_next  = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                end else if (w_timeout) begin
                    w_err_next     = 1'b1;
                    w_state_next   = ST_IDLE;
                    w_cpu_en_next  = 1'b0;
                    w_cpu_rst_next = 1'b1;
                end else begin
                    w_to_next = r_to_cnt + TO_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_imem_data  = r_imem_data;
    assign o_imem_waddr = r_imem_waddr;
    assign o_imem_wen   = r_wen;
    assign o_mem_wsize  = WSIZE_WORD;
    assign o_cpu_en     = r_cpu_en;
    assign o_cpu_rst    = r_cpu_rst;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule : imem_loader
`default_nettype wire
